// File: rtl/ibex_xif_csr_bank_pkg.sv
// Shared types and helpers for the XIF CSR bank.
package ibex_xif_csr_bank_pkg;

  // Widest register the bank supports; the merge helper works at this width.
  localparam int CsrMaxWidth = 64;

  typedef enum logic [0:0] {
    CSR_IDLE   = 1'b0,
    CSR_STAGED = 1'b1
  } csr_bank_state_e;

  // Bits selected by mask take the new data, the rest keep the current value.
  function automatic logic [CsrMaxWidth-1:0] csr_merge(input logic [CsrMaxWidth-1:0] cur,
                                                       input logic [CsrMaxWidth-1:0] data,
                                                       input logic [CsrMaxWidth-1:0] mask);
    return (cur & ~mask) | (data & mask);
  endfunction

endpackage

`ifndef ASSERT_KNOWN
`define ASSERT_KNOWN(name_, sig_) \
  name_: assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(sig_));
`endif

// File: rtl/ibex_xif_csr_slot.sv
// One CSR: committed value plus an optional inverted shadow and its mismatch flag.
module ibex_xif_csr_slot #(
  parameter int               Width      = 32,
  parameter bit               ShadowCopy = 1'b1,
  parameter logic [Width-1:0] ResetVal   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] q_o,
  output logic             mismatch_o
);

  logic [Width-1:0] value_q, value_d;

  // Next committed value: hold unless this slot is written.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    value_d = value_q;
    if (we_i) value_d = wdata_i;
  end

  // Committed value register.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (rst_i) value_q <= ResetVal;
    else       value_q <= value_d;
  end

  assign q_o = value_q;

  if (ShadowCopy) begin : g_shadow
    logic [Width-1:0] shadow_q, shadow_d;

    // Shadow tracks the inverse of every committed value.
    always_comb begin
      shadow_d = shadow_q;
      if (we_i) shadow_d = ~wdata_i;
    end

    // Shadow register, reset to the inverse of the reset value.
    always_ff @(posedge clk_i) begin
      if (rst_i) shadow_q <= ~ResetVal;
      else       shadow_q <= shadow_d;
    end

    assign mismatch_o = (value_q != ~shadow_q);
  end else begin : g_no_shadow
    assign mismatch_o = 1'b0;
  end

endmodule

// File: rtl/ibex_xif_csr_bank.sv
// Bank of masked-write CSRs with shadow checking and optional stage-then-confirm writes.
module ibex_xif_csr_bank
  import ibex_xif_csr_bank_pkg::*;
#(
  parameter int                             Width         = 32,
  parameter int                             NumRegs       = 4,
  localparam int                            AddrW         = (NumRegs > 1) ? $clog2(NumRegs) : 1,
  parameter bit                             ShadowCopy    = 1'b1,
  parameter bit                             TwoPhaseWrite = 1'b0,
  parameter logic [NumRegs-1:0][Width-1:0]  ResetValue    = '0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wr_en_i,
  input  logic [AddrW-1:0]                wr_addr_i,
  input  logic [Width-1:0]                wr_data_i,
  input  logic [Width-1:0]                wr_mask_i,
  input  logic                            abort_i,
  input  logic [AddrW-1:0]                rd_addr_i,
  output logic [Width-1:0]                rd_data_o,
  output logic                            rd_error_o,
  output logic [NumRegs-1:0][Width-1:0]   regs_o,
  output logic                            staged_o,
  output logic                            upd_err_o,
  output logic                            fatal_o
);

  logic [NumRegs-1:0] mismatch;
  logic [NumRegs-1:0] slot_we;
  logic [Width-1:0]   wr_cur;
  logic [Width-1:0]   wr_merged;
  logic               wr_in_range;
  logic               commit;

  // Address decode for both ports; unmatched addresses read as zero.
  always_comb begin
    wr_cur      = '0;
    wr_in_range = 1'b0;
    rd_data_o   = '0;
    rd_error_o  = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      if (wr_addr_i == AddrW'(i)) begin
        wr_cur      = regs_o[i];
        wr_in_range = 1'b1;
      end
      if (rd_addr_i == AddrW'(i)) begin
        rd_data_o  = regs_o[i];
        rd_error_o = mismatch[i];
      end
    end
  end

  assign wr_merged = Width'(csr_merge(CsrMaxWidth'(wr_cur), CsrMaxWidth'(wr_data_i),
                                      CsrMaxWidth'(wr_mask_i)));

  if (TwoPhaseWrite) begin : g_two_phase
    csr_bank_state_e  state_q, state_d;
    logic [AddrW-1:0] stg_addr_q, stg_addr_d;
    logic [Width-1:0] stg_val_q, stg_val_d;
    logic             upd_err_q, upd_err_d;

    // Stage on the first write, commit only on an identical confirming write.
    always_comb begin
      state_d    = state_q;
      stg_addr_d = stg_addr_q;
      stg_val_d  = stg_val_q;
      upd_err_d  = 1'b0;
      commit     = 1'b0;
      unique case (state_q)
        CSR_IDLE: begin
          if (wr_en_i && wr_in_range) begin
            stg_addr_d = wr_addr_i;
            stg_val_d  = wr_merged;
            state_d    = CSR_STAGED;
          end
        end
        CSR_STAGED: begin
          if (abort_i) begin
            state_d = CSR_IDLE;
          end else if (wr_en_i) begin
            state_d = CSR_IDLE;
            if (wr_in_range && (wr_addr_i == stg_addr_q) && (wr_merged == stg_val_q)) begin
              commit = 1'b1;
            end else begin
              upd_err_d = 1'b1;
            end
          end
        end
        default: state_d = CSR_IDLE;
      endcase
    end

    // Staging state, staged address/value and the error pulse.
    always_ff @(posedge clk_i) begin
      // NOTE: staged data is reset too, so it never carries X into a comparison.
      if (rst_i) begin
        state_q    <= CSR_IDLE;
        stg_addr_q <= '0;
        stg_val_q  <= '0;
        upd_err_q  <= 1'b0;
      end else begin
        state_q    <= state_d;
        stg_addr_q <= stg_addr_d;
        stg_val_q  <= stg_val_d;
        upd_err_q  <= upd_err_d;
      end
    end

    assign staged_o  = (state_q == CSR_STAGED);
    assign upd_err_o = upd_err_q;
  end else begin : g_one_phase
    logic unused_abort;
    assign unused_abort = abort_i;
    assign commit       = wr_en_i && wr_in_range;
    assign staged_o     = 1'b0;
    assign upd_err_o    = 1'b0;
  end

  for (genvar i = 0; i < NumRegs; i++) begin : g_slot
    assign slot_we[i] = commit && (wr_addr_i == AddrW'(i));

    ibex_xif_csr_slot #(
      .Width      (Width),
      .ShadowCopy (ShadowCopy),
      .ResetVal   (ResetValue[i])
    ) u_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .we_i       (slot_we[i]),
      .wdata_i    (wr_merged),
      .q_o        (regs_o[i]),
      .mismatch_o (mismatch[i])
    );
  end

  logic fatal_q, fatal_d;

  // Sticky fatal flag: any shadow mismatch latches it until reset.
  always_comb begin
    fatal_d = fatal_q | (|mismatch);
  end

  // Fatal flag register.
  always_ff @(posedge clk_i) begin
    if (rst_i) fatal_q <= 1'b0;
    else       fatal_q <= fatal_d;
  end

  assign fatal_o = fatal_q;

`ifndef SYNTHESIS
  `ASSERT_KNOWN(wr_en_known_a, wr_en_i)
  `ASSERT_KNOWN(abort_known_a, abort_i)
  `ASSERT_KNOWN(rd_addr_known_a, rd_addr_i)
`endif

endmodule

// File: tb/tb_ibex_xif_csr_bank.sv
// Randomized and directed bench for ibex_xif_csr_bank against a behavioural model.
// Three instances share stimulus: 4 regs single-phase, 4 regs two-phase, 3 regs two-phase.
module tb_ibex_xif_csr_bank;

  localparam logic [3:0][31:0] RV4 = {32'h0000_0000, 32'hA5A5_0000, 32'h0000_0000, 32'hDEAD_0001};
  localparam logic [2:0][31:0] RV3 = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] wr_mask = '0;
  logic        abort = 1'b0;
  logic [1:0]  rd_addr = 2'd2;

  logic [31:0]      rd_data_a, rd_data_b, rd_data_c;
  logic             rd_error_a, rd_error_b, rd_error_c;
  logic [3:0][31:0] regs_a, regs_b;
  logic [2:0][31:0] regs_c;
  logic             staged_a, staged_b, staged_c;
  logic             upd_err_a, upd_err_b, upd_err_c;
  logic             fatal_a, fatal_b, fatal_c;

  always #5 clk = ~clk;

  ibex_xif_csr_bank #(.Width(32), .NumRegs(4), .ShadowCopy(1'b1), .TwoPhaseWrite(1'b0),
                      .ResetValue(RV4)) dut_a (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_mask_i(wr_mask), .abort_i(abort), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .rd_error_o(rd_error_a), .regs_o(regs_a), .staged_o(staged_a), .upd_err_o(upd_err_a),
    .fatal_o(fatal_a));

  ibex_xif_csr_bank #(.Width(32), .NumRegs(4), .ShadowCopy(1'b1), .TwoPhaseWrite(1'b1),
                      .ResetValue(RV4)) dut_b (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_mask_i(wr_mask), .abort_i(abort), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_error_o(rd_error_b), .regs_o(regs_b), .staged_o(staged_b), .upd_err_o(upd_err_b),
    .fatal_o(fatal_b));

  ibex_xif_csr_bank #(.Width(32), .NumRegs(3), .ShadowCopy(1'b0), .TwoPhaseWrite(1'b1),
                      .ResetValue(RV3)) dut_c (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_mask_i(wr_mask), .abort_i(abort), .rd_addr_i(rd_addr), .rd_data_o(rd_data_c),
    .rd_error_o(rd_error_c), .regs_o(regs_c), .staged_o(staged_c), .upd_err_o(upd_err_c),
    .fatal_o(fatal_c));

  int n_tests = 0;
  int n_fail  = 0;
  bit model_on = 1'b1;

  // Reference model: register contents plus one pending staged write per instance.
  logic [31:0] m_regs  [3][4];
  bit          m_pend  [3];
  logic [1:0]  m_paddr [3];
  logic [31:0] m_pval  [3];
  bit          m_err   [3];
  int          n_regs    [3] = '{4, 4, 3};
  bit          two_phase [3] = '{1'b0, 1'b1, 1'b1};

  logic [31:0] shadow_force;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reset_of(input int d, input int i);
    if (d == 2) return (i < 3) ? RV3[i] : 32'h0;
    return RV4[i];
  endfunction

  task automatic model_step();
    logic [31:0] cur, merged;
    bit          in_range;
    for (int d = 0; d < 3; d++) begin
      m_err[d] = 1'b0;
      if (rst) begin
        for (int i = 0; i < 4; i++) m_regs[d][i] = reset_of(d, i);
        m_pend[d] = 1'b0;
        continue;
      end
      in_range = int'(wr_addr) < n_regs[d];
      cur      = in_range ? m_regs[d][wr_addr] : 32'h0;
      merged   = (cur & ~wr_mask) | (wr_data & wr_mask);
      if (!two_phase[d]) begin
        if (wr_en && in_range) m_regs[d][wr_addr] = merged;
      end else if (!m_pend[d]) begin
        if (wr_en && in_range) begin
          m_pend[d]  = 1'b1;
          m_paddr[d] = wr_addr;
          m_pval[d]  = merged;
        end
      end else if (abort) begin
        m_pend[d] = 1'b0;
      end else if (wr_en) begin
        m_pend[d] = 1'b0;
        if (in_range && wr_addr == m_paddr[d] && merged == m_pval[d]) m_regs[d][wr_addr] = merged;
        else m_err[d] = 1'b1;
      end
    end
  endtask

  task automatic compare_one(input int d, input logic [31:0] rd, input logic rde,
                             input logic [127:0] regs, input logic st, input logic ue,
                             input logic fat);
    logic [127:0] exp_regs;
    logic [31:0]  exp_rd;
    exp_regs = '0;
    for (int i = 0; i < n_regs[d]; i++) exp_regs[i*32 +: 32] = m_regs[d][i];
    exp_rd = (int'(rd_addr) < n_regs[d]) ? m_regs[d][rd_addr] : 32'h0;
    check($sformatf("rd_data[%0d]", d), 128'(rd), 128'(exp_rd));
    check($sformatf("rd_error[%0d]", d), 128'(rde), 128'(0));
    check($sformatf("regs[%0d]", d), regs, exp_regs);
    check($sformatf("staged[%0d]", d), 128'(st), 128'(m_pend[d]));
    check($sformatf("upd_err[%0d]", d), 128'(ue), 128'(m_err[d]));
    check($sformatf("fatal[%0d]", d), 128'(fat), 128'(0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (model_on) begin
      compare_one(0, rd_data_a, rd_error_a, 128'(regs_a), staged_a, upd_err_a, fatal_a);
      compare_one(1, rd_data_b, rd_error_b, 128'(regs_b), staged_b, upd_err_b, fatal_b);
      compare_one(2, rd_data_c, rd_error_c, 128'(regs_c), staged_c, upd_err_c, fatal_c);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] data, input logic [31:0] mask);
    wr_en = 1'b1; wr_addr = a; wr_data = data; wr_mask = mask;
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset state.
    rst = 1'b1; rd_addr = 2'd2;
    cycle(); cycle();
    check("reset_rd_data", 128'(rd_data_a), 128'(32'hA5A5_0000));
    check("reset_rd_error", 128'(rd_error_a), 128'(0));
    check("reset_fatal", 128'(fatal_a), 128'(0));
    rst = 1'b0;
    cycle();

    // Masked writes merge against the committed value.
    rd_addr = 2'd1;
    wr(2'd1, 32'hFFFF_FFFF, 32'h0000_00F0);
    check("mask_set", 128'(rd_data_a), 128'(32'h0000_00F0));
    wr(2'd1, 32'h0, 32'h0000_0010);
    check("mask_clear", 128'(rd_data_a), 128'(32'h0000_00E0));
    cycle();

    // Two identical writes commit; the first only stages. Out-of-range is ignored in IDLE.
    rd_addr = 2'd3;
    wr(2'd3, 32'h1234, 32'hFFFF_FFFF);
    check("tp_first_reg3", 128'(regs_b[3]), 128'(0));
    check("tp_first_staged", 128'(staged_b), 128'(1));
    check("oor_idle_staged", 128'(staged_c), 128'(0));
    wr(2'd3, 32'h1234, 32'hFFFF_FFFF);
    check("tp_confirm_reg3", 128'(regs_b[3]), 128'(32'h1234));
    check("tp_confirm_staged", 128'(staged_b), 128'(0));
    check("oor_read_zero", 128'(rd_data_c), 128'(0));
    cycle();

    // Confirm with a different value, then with a different address.
    wr(2'd0, 32'h1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h2, 32'hFFFF_FFFF);
    check("mm_val_upd_err", 128'(upd_err_b), 128'(1));
    check("mm_val_reg0", 128'(regs_b[0]), 128'(32'hDEAD_0001));
    check("mm_val_staged", 128'(staged_b), 128'(0));
    cycle();
    check("mm_val_pulse_end", 128'(upd_err_b), 128'(0));
    wr(2'd0, 32'h1, 32'hFFFF_FFFF);
    wr(2'd1, 32'h1, 32'hFFFF_FFFF);
    check("mm_addr_upd_err", 128'(upd_err_b), 128'(1));
    check("mm_addr_reg0", 128'(regs_b[0]), 128'(32'hDEAD_0001));
    check("mm_addr_staged", 128'(staged_b), 128'(0));
    cycle();

    // Out-of-range confirm counts as a mismatch.
    wr(2'd0, 32'h5, 32'hFFFF_FFFF);
    wr(2'd3, 32'h5, 32'hFFFF_FFFF);
    check("oor_confirm_upd_err", 128'(upd_err_c), 128'(1));
    cycle();

    // Abort beats a simultaneous write.
    rd_addr = 2'd2;
    wr(2'd2, 32'h7, 32'hFFFF_FFFF);
    abort = 1'b1;
    wr(2'd2, 32'h7, 32'hFFFF_FFFF);
    abort = 1'b0;
    check("abort_staged", 128'(staged_b), 128'(0));
    check("abort_upd_err", 128'(upd_err_b), 128'(0));
    check("abort_reg2", 128'(regs_b[2]), 128'(32'hA5A5_0000));
    cycle();
    check("abort_no_late_err", 128'(upd_err_b), 128'(0));

    // Reset while staged discards the staged write.
    wr(2'd2, 32'h7, 32'hFFFF_FFFF);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_staged", 128'(staged_b), 128'(0));
    check("rst_reg2", 128'(regs_b[2]), 128'(32'hA5A5_0000));
    wr(2'd2, 32'h7, 32'hFFFF_FFFF);
    check("rst_restage_reg2", 128'(regs_b[2]), 128'(32'hA5A5_0000));
    check("rst_restage_staged", 128'(staged_b), 128'(1));
    abort = 1'b1;
    cycle();
    abort = 1'b0;

    // Randomized traffic; repeated writes give two-phase confirms a chance.
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 49) == 0);
      abort = ($urandom_range(0, 9) == 0);
      if (!(wr_en && $urandom_range(0, 9) < 4)) begin
        wr_en   = ($urandom_range(0, 1) == 1);
        wr_addr = 2'($urandom_range(0, 3));
        wr_data = $urandom;
        case ($urandom_range(0, 2))
          0:       wr_mask = 32'hFFFF_FFFF;
          1:       wr_mask = $urandom;
          default: wr_mask = 32'h0000_FFFF;
        endcase
      end
      rd_addr = 2'($urandom_range(0, 3));
      cycle();
    end
    rst = 1'b0; abort = 1'b0; wr_en = 1'b0;
    cycle();

    // Corrupt the shadow of reg2 in the single-phase instance.
    model_on = 1'b0;
    rd_addr = 2'd2;
    shadow_force = ~m_regs[0][2] ^ 32'h0000_0020;
    force dut_a.g_slot[2].u_slot.g_shadow.shadow_q = shadow_force;
    #1;
    check("shadow_rd_error", 128'(rd_error_a), 128'(1));
    check("shadow_fatal_pre", 128'(fatal_a), 128'(0));
    cycle();
    check("shadow_fatal", 128'(fatal_a), 128'(1));
    release dut_a.g_slot[2].u_slot.g_shadow.shadow_q;
    cycle();
    cycle();
    check("shadow_fatal_sticky", 128'(fatal_a), 128'(1));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("shadow_fatal_rst", 128'(fatal_a), 128'(0));
    check("shadow_rd_error_rst", 128'(rd_error_a), 128'(0));
    model_on = 1'b1;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
